// File: rtl/mem_alu_pipe_if.sv
// Instruction and result streams of mem_alu_pipe: valid/ready on both sides.
// The slave modport is the pipeline itself; the master is the sequencer/consumer side.
interface mem_alu_pipe_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
);
   localparam int INSTR_W = 4 + 3 * ADDR_W;

   logic               in_valid;
   logic               in_ready;
   logic [INSTR_W-1:0] instr;
   logic               out_valid;
   logic               out_ready;
   logic [DATA_W-1:0]  out_data;
   logic [ADDR_W-1:0]  out_dst;
   logic               out_zero;
   logic               out_err;

   modport master (
      output in_valid, instr, out_ready,
      input  in_ready, out_valid, out_data, out_dst, out_zero, out_err
   );

   modport slave (
      input  in_valid, instr, out_ready,
      output in_ready, out_valid, out_data, out_dst, out_zero, out_err
   );
endinterface

// File: rtl/mem_alu_pipe.sv
// Register-memory ALU, 2-stage pipe (fetch -> execute/writeback); accept at edge k, result at k+1.
// A stalled result output holds EX and drops in_ready; full rate when out_ready stays high.
module mem_alu_pipe #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   mem_alu_pipe_if.slave              bus,
   input  logic [ADDR_W-1:0]          dbg_addr,
   output logic [DATA_W-1:0]          dbg_data,
   output logic [(DATA_W<<ADDR_W)-1:0] memory
);
   localparam int DEPTH = 1 << ADDR_W;
   localparam int IMM_W = 2 * ADDR_W;
   localparam logic [DATA_W:0] DW_L = (DATA_W + 1)'(DATA_W);

   typedef enum logic [3:0] {
      OP_LDI = 4'd0,  OP_EQ  = 4'd1,  OP_LT  = 4'd2,  OP_LE  = 4'd3,
      OP_OR  = 4'd4,  OP_SHL = 4'd5,  OP_SHR = 4'd6,  OP_MOV = 4'd7,
      OP_AND = 4'd8,  OP_XOR = 4'd9,  OP_NOT = 4'd10, OP_ADD = 4'd11,
      OP_SUB = 4'd12, OP_MUL = 4'd13, OP_DIV = 4'd14, OP_MOD = 4'd15
   } op_e;

   typedef struct packed {
      op_e               op;
      logic [ADDR_W-1:0] src1;
      logic [ADDR_W-1:0] src2;
      logic [ADDR_W-1:0] dst;
   } instr_t;

   typedef struct packed {
      op_e               op;
      logic [IMM_W-1:0]  imm;
      logic [DATA_W-1:0] r1;
      logic [DATA_W-1:0] r2;
      logic [ADDR_W-1:0] dst;
   } ex_t;

   logic [DATA_W-1:0] mem [DEPTH];
   instr_t            in_w;
   ex_t               ex_q;
   logic              ex_valid;
   logic              ex_fire;
   logic              accept;
   logic [DATA_W-1:0] op1;
   logic [DATA_W-1:0] op2;
   logic [DATA_W-1:0] result;
   logic              result_err;
   logic              shamt_ok;

   logic              out_valid_q;
   logic [DATA_W-1:0] out_data_q;
   logic [ADDR_W-1:0] out_dst_q;
   logic              out_zero_q;
   logic              out_err_q;

   assign in_w         = instr_t'(bus.instr);
   assign ex_fire      = ex_valid && (!out_valid_q || bus.out_ready);
   assign bus.in_ready = !ex_valid || ex_fire;
   assign accept       = bus.in_valid && bus.in_ready;

   // The EX result is not in memory yet when the next instruction fetches; bypass it.
   always_comb begin
      op1 = mem[in_w.src1];
      op2 = mem[in_w.src2];
      if (ex_valid && (in_w.src1 == ex_q.dst)) op1 = result;
      if (ex_valid && (in_w.src2 == ex_q.dst)) op2 = result;
   end

   assign shamt_ok = ({1'b0, ex_q.r2} < DW_L);

   always_comb begin
      result     = '0;
      result_err = 1'b0;
      case (ex_q.op)
         OP_LDI: result = DATA_W'(ex_q.imm);
         OP_EQ:  result = DATA_W'(ex_q.r1 == ex_q.r2);
         OP_LT:  result = DATA_W'(ex_q.r1 <  ex_q.r2);
         OP_LE:  result = DATA_W'(ex_q.r1 <= ex_q.r2);
         OP_OR:  result = ex_q.r1 | ex_q.r2;
         OP_SHL: result = shamt_ok ? (ex_q.r1 << ex_q.r2) : '0;
         OP_SHR: result = shamt_ok ? (ex_q.r1 >> ex_q.r2) : '0;
         OP_MOV: result = ex_q.r1;
         OP_AND: result = ex_q.r1 & ex_q.r2;
         OP_XOR: result = ex_q.r1 ^ ex_q.r2;
         OP_NOT: result = ~ex_q.r1;
         OP_ADD: result = ex_q.r1 + ex_q.r2;
         OP_SUB: result = ex_q.r1 - ex_q.r2;
         OP_MUL: result = ex_q.r1 * ex_q.r2;
         OP_DIV: begin
            if (ex_q.r2 == '0) begin
               result     = '1;
               result_err = 1'b1;
            end else begin
               result = ex_q.r1 / ex_q.r2;
            end
         end
         OP_MOD: begin
            if (ex_q.r2 == '0) begin
               result     = ex_q.r1;
               result_err = 1'b1;
            end else begin
               result = ex_q.r1 % ex_q.r2;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_valid <= 1'b0;
         ex_q     <= '0;
      end else if (accept) begin
         ex_valid <= 1'b1;
         ex_q     <= '{op: in_w.op, imm: {in_w.src1, in_w.src2},
                       r1: op1, r2: op2, dst: in_w.dst};
      end else if (ex_fire) begin
         ex_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_dst_q   <= '0;
         out_zero_q  <= 1'b0;
         out_err_q   <= 1'b0;
      end else if (ex_fire) begin
         out_valid_q <= 1'b1;
         out_data_q  <= result;
         out_dst_q   <= ex_q.dst;
         out_zero_q  <= (result == '0);
         out_err_q   <= result_err;
      end else if (bus.out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
      end else if (ex_fire) begin
         mem[ex_q.dst] <= result;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_dst   = out_dst_q;
   assign bus.out_zero  = out_zero_q;
   assign bus.out_err   = out_err_q;

   assign dbg_data = mem[dbg_addr];

   for (genvar k = 0; k < DEPTH; k++) begin : g_img
      assign memory[k*DATA_W +: DATA_W] = mem[k];
   end
endmodule

// File: tb/tb_mem_alu_pipe.sv
// Scoreboard bench for mem_alu_pipe: an 8-bit/16-word and a 16-bit/32-word instance,
// each checked against an architectural (sequential ISA) model.
module tb_mem_alu_pipe;
   localparam logic [3:0] OP_LDI = 4'd0,  OP_EQ  = 4'd1,  OP_LT  = 4'd2,  OP_LE  = 4'd3;
   localparam logic [3:0] OP_OR  = 4'd4,  OP_SHL = 4'd5,  OP_SHR = 4'd6,  OP_MOV = 4'd7;
   localparam logic [3:0] OP_AND = 4'd8,  OP_XOR = 4'd9,  OP_NOT = 4'd10, OP_ADD = 4'd11;
   localparam logic [3:0] OP_SUB = 4'd12, OP_MUL = 4'd13, OP_DIV = 4'd14, OP_MOD = 4'd15;

   typedef struct packed {
      logic [15:0] data;
      logic [4:0]  dst;
      logic        zero;
      logic        err;
   } res_t;

   logic         clk = 1'b0;
   logic         rst;
   logic [3:0]   dbg8;
   logic [4:0]   dbg16;
   logic [7:0]   dd8;
   logic [15:0]  dd16;
   logic [127:0] mem8;
   logic [511:0] mem16;

   int   n_chk  = 0;
   int   n_fail = 0;
   bit   rnd_ordy = 1'b0;
   res_t q8[$];
   res_t q16[$];
   logic [15:0] sh8 [16];
   logic [15:0] sh16 [32];

   always #5 clk = ~clk;

   mem_alu_pipe_if #(.DATA_W(8),  .ADDR_W(4)) i8 ();
   mem_alu_pipe_if #(.DATA_W(16), .ADDR_W(5)) i16 ();

   mem_alu_pipe #(.DATA_W(8), .ADDR_W(4)) dut8 (
      .clk(clk), .rst(rst), .bus(i8),
      .dbg_addr(dbg8), .dbg_data(dd8), .memory(mem8)
   );

   mem_alu_pipe #(.DATA_W(16), .ADDR_W(5)) dut16 (
      .clk(clk), .rst(rst), .bus(i16),
      .dbg_addr(dbg16), .dbg_data(dd16), .memory(mem16)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic void alu_ref(input logic [3:0] op, input int unsigned a, input int unsigned b,
                                   input int unsigned imm, input int unsigned dw,
                                   output int unsigned r, output logic e);
      int unsigned m;
      m = (32'd1 << dw) - 32'd1;
      e = 1'b0;
      case (op)
         OP_LDI: r = imm;
         OP_EQ:  r = (a == b) ? 1 : 0;
         OP_LT:  r = (a <  b) ? 1 : 0;
         OP_LE:  r = (a <= b) ? 1 : 0;
         OP_OR:  r = a | b;
         OP_SHL: r = (b >= dw) ? 0 : (a << b);
         OP_SHR: r = (b >= dw) ? 0 : (a >> b);
         OP_MOV: r = a;
         OP_AND: r = a & b;
         OP_XOR: r = a ^ b;
         OP_NOT: r = ~a;
         OP_ADD: r = a + b;
         OP_SUB: r = a - b;
         OP_MUL: r = a * b;
         OP_DIV: if (b == 0) begin r = m; e = 1'b1; end else r = a / b;
         default: if (b == 0) begin r = a; e = 1'b1; end else r = a % b;
      endcase
      r = r & m;
   endfunction

   function automatic logic [15:0] rdmem(input bit sel, input int k);
      return sel ? mem16[k*16 +: 16] : {8'h00, mem8[k*8 +: 8]};
   endfunction

   task automatic set_ordy(input bit sel, input logic v);
      if (sel) i16.out_ready = v;
      else     i8.out_ready  = v;
   endtask

   // Model is updated at acceptance in program order; in-order retirement makes that exact.
   task automatic model_push(input bit sel, input logic [3:0] op, input logic [4:0] a,
                             input logic [4:0] b, input logic [4:0] d);
      int unsigned r;
      logic        e;
      res_t        x;
      if (sel) begin
         alu_ref(op, sh16[a], sh16[b], {22'd0, a, b}, 16, r, e);
         sh16[d] = r[15:0];
         x = '{data: r[15:0], dst: d, zero: (r == 0), err: e};
         q16.push_back(x);
      end else begin
         alu_ref(op, sh8[a[3:0]], sh8[b[3:0]], {24'd0, a[3:0], b[3:0]}, 8, r, e);
         sh8[d[3:0]] = r[15:0];
         x = '{data: r[15:0], dst: {1'b0, d[3:0]}, zero: (r == 0), err: e};
         q8.push_back(x);
      end
   endtask

   task automatic issue(input bit sel, input logic [3:0] op, input logic [4:0] a,
                        input logic [4:0] b, input logic [4:0] d);
      bit done = 1'b0;
      if (sel) begin
         i16.instr = {op, a, b, d};
         i16.in_valid = 1'b1;
      end else begin
         i8.instr = {op, a[3:0], b[3:0], d[3:0]};
         i8.in_valid = 1'b1;
      end
      for (int t = 0; t < 200 && !done; t++) begin
         @(negedge clk);
         if ((sel ? i16.in_ready : i8.in_ready) === 1'b1) begin
            model_push(sel, op, a, b, d);
            done = 1'b1;
         end
         @(posedge clk);
         #1;
         if (rnd_ordy) set_ordy(sel, 1'($urandom_range(0, 1)));
      end
      if (!done) check("accept_timeout", 32'(sel ? i16.in_ready : i8.in_ready), 32'd1);
      if (sel) i16.in_valid = 1'b0;
      else     i8.in_valid  = 1'b0;
   endtask

   task automatic ldi(input bit sel, input logic [9:0] imm, input logic [4:0] d);
      if (sel) issue(1'b1, OP_LDI, imm[9:5], imm[4:0], d);
      else     issue(1'b0, OP_LDI, {1'b0, imm[7:4]}, {1'b0, imm[3:0]}, d);
   endtask

   task automatic drain(input bit sel);
      set_ordy(sel, 1'b1);
      for (int t = 0; t < 200 && (sel ? q16.size() : q8.size()) != 0; t++) begin
         @(posedge clk);
         #1;
      end
      check("drain_pending", 32'(sel ? q16.size() : q8.size()), 32'd0);
   endtask

   task automatic mem_check(input bit sel);
      for (int k = 0; k < (sel ? 32 : 16); k++)
         check(sel ? "mem16_word" : "mem8_word", 32'(rdmem(sel, k)), 32'(sel ? sh16[k] : sh8[k]));
   endtask

   task automatic t2(input bit sel);
      ldi(sel, 10'd5, 5'd1);
      ldi(sel, 10'd7, 5'd2);
      issue(sel, OP_ADD, 5'd1, 5'd2, 5'd3);
      issue(sel, OP_MUL, 5'd3, 5'd3, 5'd4);
      drain(sel);
      check("b2b_m3", 32'(rdmem(sel, 3)), 32'h0C);
      check("b2b_m4", 32'(rdmem(sel, 4)), 32'h90);
      mem_check(sel);
   endtask

   task automatic t5(input bit sel);
      issue(sel, OP_NOT, 5'd0, 5'd0, 5'd10);
      ldi(sel, 10'd1, 5'd11);
      issue(sel, OP_ADD, 5'd10, 5'd11, 5'd12);
      issue(sel, OP_SUB, 5'd0, 5'd11, 5'd13);
      ldi(sel, 10'd8, 5'd14);
      issue(sel, OP_SHL, 5'd11, 5'd14, 5'd15);
      ldi(sel, 10'd16, 5'd14);
      issue(sel, OP_SHL, 5'd11, 5'd14, 5'd7);
      ldi(sel, 10'h0F, 5'd9);
      issue(sel, OP_NOT, 5'd9, 5'd9, 5'd9);
      ldi(sel, 10'd3, 5'd5);
      ldi(sel, 10'd200, 5'd6);
      issue(sel, OP_LT, 5'd5, 5'd6, 5'd8);
      issue(sel, OP_SHR, 5'd10, 5'd11, 5'd4);
      issue(sel, OP_LE, 5'd6, 5'd5, 5'd3);
      drain(sel);
      check("wrap_add", 32'(rdmem(sel, 12)), 32'h0);
      check("wrap_sub", 32'(rdmem(sel, 13)), sel ? 32'hFFFF : 32'hFF);
      check("shl_by_8", 32'(rdmem(sel, 15)), sel ? 32'h100 : 32'h0);
      check("shl_by_16", 32'(rdmem(sel, 7)), 32'h0);
      check("not_0f", 32'(rdmem(sel, 9)), sel ? 32'hFFF0 : 32'hF0);
      check("lt_3_200", 32'(rdmem(sel, 8)), 32'h1);
      check("shr_ones", 32'(rdmem(sel, 4)), sel ? 32'h7FFF : 32'h7F);
      mem_check(sel);
   endtask

   task automatic rnd(input bit sel, input int n);
      rnd_ordy = 1'b1;
      for (int i = 0; i < n; i++) begin
         issue(sel, 4'($urandom_range(0, 15)), 5'($urandom_range(0, sel ? 31 : 15)),
               5'($urandom_range(0, sel ? 31 : 15)), 5'($urandom_range(0, sel ? 31 : 15)));
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
            set_ordy(sel, 1'($urandom_range(0, 1)));
         end
      end
      rnd_ordy = 1'b0;
      drain(sel);
      mem_check(sel);
   endtask

   always @(negedge clk) begin : mon8
      res_t e;
      if (!rst && i8.out_valid && i8.out_ready) begin
         if (q8.size() == 0) check("out8_spurious", 32'(i8.out_valid), 32'd0);
         else begin
            e = q8.pop_front();
            check("out8_data", 32'(i8.out_data), 32'(e.data));
            check("out8_dst",  32'(i8.out_dst),  32'(e.dst));
            check("out8_zero", 32'(i8.out_zero), 32'(e.zero));
            check("out8_err",  32'(i8.out_err),  32'(e.err));
         end
      end
   end

   always @(negedge clk) begin : mon16
      res_t e;
      if (!rst && i16.out_valid && i16.out_ready) begin
         if (q16.size() == 0) check("out16_spurious", 32'(i16.out_valid), 32'd0);
         else begin
            e = q16.pop_front();
            check("out16_data", 32'(i16.out_data), 32'(e.data));
            check("out16_dst",  32'(i16.out_dst),  32'(e.dst));
            check("out16_zero", 32'(i16.out_zero), 32'(e.zero));
            check("out16_err",  32'(i16.out_err),  32'(e.err));
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      i8.in_valid = 1'b0;  i8.instr = '0;  i8.out_ready = 1'b1;
      i16.in_valid = 1'b0; i16.instr = '0; i16.out_ready = 1'b1;
      dbg8 = '0; dbg16 = '0;
      for (int k = 0; k < 16; k++) sh8[k] = '0;
      for (int k = 0; k < 32; k++) sh16[k] = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      check("rst_out_valid", 32'(i8.out_valid), 32'd0);
      check("rst_out_data",  32'(i8.out_data),  32'd0);
      check("rst_in_ready",  32'(i8.in_ready),  32'd1);
      mem_check(1'b0);
      mem_check(1'b1);

      // Single LDI: result must appear exactly one edge after acceptance.
      ldi(1'b0, 10'h2A, 5'd3);
      @(negedge clk);
      check("lat_early_valid", 32'(i8.out_valid), 32'd0);
      @(posedge clk);
      #1;
      dbg8 = 4'd3;
      #1;
      check("ldi_out_valid", 32'(i8.out_valid), 32'd1);
      check("ldi_out_data",  32'(i8.out_data),  32'h2A);
      check("ldi_out_dst",   32'(i8.out_dst),   32'd3);
      check("ldi_dbg_data",  32'(dd8),          32'h2A);
      check("ldi_mem3",      32'(rdmem(1'b0, 3)), 32'h2A);
      drain(1'b0);

      t2(1'b0);

      ldi(1'b0, 10'd9, 5'd1);
      issue(1'b0, OP_DIV, 5'd1, 5'd0, 5'd4);
      issue(1'b0, OP_MOD, 5'd1, 5'd0, 5'd5);
      issue(1'b0, OP_DIV, 5'd1, 5'd1, 5'd6);
      drain(1'b0);
      check("div0_m4", 32'(rdmem(1'b0, 4)), 32'hFF);
      check("mod0_m5", 32'(rdmem(1'b0, 5)), 32'h09);
      check("div_m6",  32'(rdmem(1'b0, 6)), 32'h01);

      // Output stall: two accepts fill the pipe, the third must wait.
      set_ordy(1'b0, 1'b0);
      ldi(1'b0, 10'h11, 5'd12);
      ldi(1'b0, 10'h22, 5'd13);
      i8.instr = {OP_LDI, 4'h3, 4'h3, 4'd14};
      i8.in_valid = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("stall_in_ready", 32'(i8.in_ready),  32'd0);
         check("stall_out_data", 32'(i8.out_data),  32'h11);
         check("stall_m12",      32'(rdmem(1'b0, 12)), 32'h11);
         check("stall_m13",      32'(rdmem(1'b0, 13)), 32'h00);
         check("stall_m14",      32'(rdmem(1'b0, 14)), 32'h00);
      end
      @(posedge clk);
      #1;
      set_ordy(1'b0, 1'b1);
      ldi(1'b0, 10'h33, 5'd14);
      drain(1'b0);
      mem_check(1'b0);

      t5(1'b0);
      rnd(1'b0, 80);

      // Reset while an instruction sits in EX: nothing of it may survive.
      ldi(1'b0, 10'h55, 5'd2);
      #2;
      rst = 1'b1;
      #1;
      check("midrst_out_valid", 32'(i8.out_valid), 32'd0);
      check("midrst_out_data",  32'(i8.out_data),  32'd0);
      check("midrst_out_dst",   32'(i8.out_dst),   32'd0);
      check("midrst_out_flags", {30'd0, i8.out_zero, i8.out_err}, 32'd0);
      for (int k = 0; k < 16; k++) check("midrst_mem", 32'(rdmem(1'b0, k)), 32'd0);
      q8.delete();
      q16.delete();
      for (int k = 0; k < 16; k++) sh8[k] = '0;
      for (int k = 0; k < 32; k++) sh16[k] = '0;
      rst = 1'b0;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      dbg8 = 4'd2;
      #1;
      check("midrst_dst_unwritten", 32'(dd8), 32'd0);
      check("midrst_in_ready", 32'(i8.in_ready), 32'd1);
      ldi(1'b0, 10'h66, 5'd2);
      drain(1'b0);
      check("postrst_m2", 32'(rdmem(1'b0, 2)), 32'h66);
      mem_check(1'b0);
      mem_check(1'b1);

      t2(1'b1);
      t5(1'b1);
      dbg16 = 5'd8;
      #1;
      check("w16_dbg_lt", 32'(dd16), 32'd1);
      rnd(1'b1, 80);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
